// File: rtl/mem_rs_multi.sv
// Multi-entry memory-pipe reservation station. It captures missing operands from the CDB
// and issues the oldest ready entry to the memory unit through a valid/ready handshake.
module mem_rs_multi #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ROB_W  = 2,
  parameter int unsigned DATA_W = 3,
  parameter int unsigned OP_W   = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         write_en,
  input  logic [ROB_W-1:0]             rob_idx,
  input  logic [OP_W-1:0]              opcode,
  input  logic [DATA_W-1:0]            val1,
  input  logic [ROB_W-1:0]             q1,
  input  logic                         ready1,
  input  logic                         cdb_en,
  input  logic [ROB_W-1:0]             cdb_rob_idx,
  input  logic [DATA_W-1:0]            cdb_val,
  input  logic                         exec_ready,
  output logic                         exec_valid,
  output logic [OP_W-1:0]              exec_opcode,
  output logic [DATA_W-1:0]            exec_val1,
  output logic [ROB_W-1:0]             exec_rob_idx,
  output logic                         rs_full,
  output logic [$clog2(DEPTH+1)-1:0]   rs_count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  rdy;
  logic [ROB_W-1:0]  e_rob [DEPTH];
  logic [OP_W-1:0]   e_op  [DEPTH];
  logic [DATA_W-1:0] e_val [DEPTH];
  logic [ROB_W-1:0]  e_q   [DEPTH];
  // older[i][j] set means entry j was allocated before entry i
  logic [DEPTH-1:0]  older [DEPTH];

  logic          sel_found;
  logic [IW-1:0] sel_idx;
  logic          alloc_found;
  logic [IW-1:0] alloc_idx;
  logic [CW-1:0] count;
  logic          do_alloc;
  logic          do_issue;
  logic          bypass_hit;

  // Oldest ready entry: ready, and no ready entry is older than it
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!sel_found && busy[i] && rdy[i] && ((busy & rdy & older[i]) == '0)) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  // Lowest-index free slot and occupancy
  always_comb begin
    alloc_found = 1'b0;
    alloc_idx   = '0;
    count       = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count = count + CW'(busy[i]);
      if (!alloc_found && !busy[i]) begin
        alloc_found = 1'b1;
        alloc_idx   = IW'(i);
      end
    end
  end

  assign rs_count     = count;
  assign rs_full      = (count == CW'(DEPTH));
  assign exec_valid   = sel_found;
  assign exec_opcode  = sel_found ? e_op[sel_idx]  : '0;
  assign exec_val1    = sel_found ? e_val[sel_idx] : '0;
  assign exec_rob_idx = sel_found ? e_rob[sel_idx] : '0;

  // Fullness comes from registered state, so a same-cycle issue cannot make room
  assign do_alloc   = write_en && !rs_full && alloc_found && !flush;
  assign do_issue   = sel_found && exec_ready && !flush;
  assign bypass_hit = !ready1 && cdb_en && (q1 == cdb_rob_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      rdy  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        older[i] <= '0;
        e_rob[i] <= '0;
        e_op[i]  <= '0;
        e_val[i] <= '0;
        e_q[i]   <= '0;
      end
    end else if (flush) begin
      busy <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        older[i] <= '0;
      end
    end else begin
      // CDB wakeup of waiting entries
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (busy[i] && !rdy[i] && cdb_en && (e_q[i] == cdb_rob_idx)) begin
          e_val[i] <= cdb_val;
          rdy[i]   <= 1'b1;
        end
      end
      if (do_issue) begin
        busy[sel_idx] <= 1'b0;
      end
      if (do_alloc) begin
        busy[alloc_idx]  <= 1'b1;
        e_rob[alloc_idx] <= rob_idx;
        e_op[alloc_idx]  <= opcode;
        e_q[alloc_idx]   <= q1;
        e_val[alloc_idx] <= bypass_hit ? cdb_val : val1;
        rdy[alloc_idx]   <= ready1 || bypass_hit;
        for (int unsigned j = 0; j < DEPTH; j++) begin
          older[j][alloc_idx] <= 1'b0;
        end
        older[alloc_idx] <= busy;
      end
    end
  end

endmodule

// File: tb/tb_mem_rs_multi.sv
// Directed self-checking bench for mem_rs_multi (DEPTH=4, ROB_W=2, DATA_W=3, OP_W=3).
module tb_mem_rs_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       write_en;
  logic [1:0] rob_idx;
  logic [2:0] opcode;
  logic [2:0] val1;
  logic [1:0] q1;
  logic       ready1;
  logic       cdb_en;
  logic [1:0] cdb_rob_idx;
  logic [2:0] cdb_val;
  logic       exec_ready;
  logic       exec_valid;
  logic [2:0] exec_opcode;
  logic [2:0] exec_val1;
  logic [1:0] exec_rob_idx;
  logic       rs_full;
  logic [2:0] rs_count;

  int passed = 0;
  int total  = 0;

  mem_rs_multi #(.DEPTH(4), .ROB_W(2), .DATA_W(3), .OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .write_en(write_en),
    .rob_idx(rob_idx), .opcode(opcode), .val1(val1), .q1(q1), .ready1(ready1),
    .cdb_en(cdb_en), .cdb_rob_idx(cdb_rob_idx), .cdb_val(cdb_val),
    .exec_ready(exec_ready), .exec_valid(exec_valid), .exec_opcode(exec_opcode),
    .exec_val1(exec_val1), .exec_rob_idx(exec_rob_idx), .rs_full(rs_full),
    .rs_count(rs_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input int unsigned r, input int unsigned op, input int unsigned v,
                      input logic rdy, input int unsigned q);
    write_en = 1'b1;
    rob_idx  = 2'(r);
    opcode   = 3'(op);
    val1     = 3'(v);
    ready1   = rdy;
    q1       = 2'(q);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; write_en = 1'b0; rob_idx = '0; opcode = '0; val1 = '0;
    q1 = '0; ready1 = 1'b0; cdb_en = 1'b0; cdb_rob_idx = '0; cdb_val = '0; exec_ready = 1'b0;
    #12;
    chk("rst_valid", 32'(exec_valid), 0);
    chk("rst_full", 32'(rs_full), 0);
    chk("rst_count", 32'(rs_count), 0);
    chk("rst_fields", 32'({exec_opcode, exec_val1, exec_rob_idx}), 0);
    rst_n = 1'b1;
    tick();

    // Fill all four entries, then drop a fifth write
    for (int r = 0; r < 4; r++) begin
      disp(32'(r), 32'(r + 1), 32'(r), 1'b1, 0);
      tick();
      chk("fill_count", 32'(rs_count), 32'(r + 1));
    end
    chk("fill_full", 32'(rs_full), 1);
    disp(0, 7, 7, 1'b1, 0);
    tick();
    write_en = 1'b0;
    chk("drop_count", 32'(rs_count), 4);
    exec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("drain_valid", 32'(exec_valid), 1);
      chk("drain_rob", 32'(exec_rob_idx), 32'(k));
      chk("drain_op", 32'(exec_opcode), 32'(k + 1));
      chk("drain_val", 32'(exec_val1), 32'(k));
      tick();
    end
    chk("drain_count", 32'(rs_count), 0);
    chk("drain_empty_valid", 32'(exec_valid), 0);

    // Waiting entry A is overtaken by ready B, then woken by the CDB
    exec_ready = 1'b0;
    disp(1, 2, 0, 1'b0, 3);
    tick();
    disp(2, 3, 5, 1'b1, 0);
    tick();
    write_en = 1'b0;
    chk("b_rob", 32'(exec_rob_idx), 2);
    chk("b_val", 32'(exec_val1), 5);
    exec_ready = 1'b1;
    tick();
    chk("a_wait_valid", 32'(exec_valid), 0);
    chk("a_wait_fields", 32'({exec_val1, exec_rob_idx}), 0);
    cdb_en = 1'b1; cdb_rob_idx = 2'd3; cdb_val = 3'd6;
    tick();
    cdb_en = 1'b0;
    chk("a_valid", 32'(exec_valid), 1);
    chk("a_rob", 32'(exec_rob_idx), 1);
    chk("a_val", 32'(exec_val1), 6);
    tick();
    chk("a_count", 32'(rs_count), 0);

    // Two entries woken by one broadcast issue in age order
    exec_ready = 1'b0;
    disp(0, 1, 0, 1'b0, 2);
    tick();
    disp(1, 1, 0, 1'b0, 2);
    tick();
    write_en = 1'b0;
    cdb_en = 1'b1; cdb_rob_idx = 2'd2; cdb_val = 3'd7;
    tick();
    cdb_en = 1'b0;
    chk("x_rob", 32'(exec_rob_idx), 0);
    chk("x_val", 32'(exec_val1), 7);
    exec_ready = 1'b1;
    tick();
    chk("y_rob", 32'(exec_rob_idx), 1);
    chk("y_val", 32'(exec_val1), 7);
    tick();
    chk("xy_count", 32'(rs_count), 0);

    // Dispatch bypass from the CDB
    exec_ready = 1'b0;
    disp(3, 4, 0, 1'b0, 1);
    cdb_en = 1'b1; cdb_rob_idx = 2'd1; cdb_val = 3'd4;
    tick();
    write_en = 1'b0; cdb_en = 1'b0;
    chk("byp_valid", 32'(exec_valid), 1);
    chk("byp_val", 32'(exec_val1), 4);
    chk("byp_rob", 32'(exec_rob_idx), 3);
    exec_ready = 1'b1;
    tick();
    chk("byp_count", 32'(rs_count), 0);

    // Full: issue and write in the same cycle, write is dropped
    exec_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      disp(32'(r), 2, 32'(r), 1'b1, 0);
      tick();
    end
    exec_ready = 1'b1;
    disp(2, 5, 3, 1'b1, 0);
    tick();
    chk("fullio_count", 32'(rs_count), 3);
    chk("fullio_full", 32'(rs_full), 0);
    exec_ready = 1'b0;
    disp(1, 6, 6, 1'b1, 0);
    tick();
    write_en = 1'b0;
    chk("refill_count", 32'(rs_count), 4);
    chk("refill_full", 32'(rs_full), 1);
    chk("refill_oldest", 32'(exec_rob_idx), 1);
    chk("refill_oldest_val", 32'(exec_val1), 1);

    // Flush with three busy entries and a concurrent write
    exec_ready = 1'b1;
    tick();
    chk("pre_flush_count", 32'(rs_count), 3);
    flush = 1'b1;
    disp(0, 1, 1, 1'b1, 0);
    chk("flush_cycle_valid", 32'(exec_valid), 1);
    tick();
    flush = 1'b0; write_en = 1'b0; exec_ready = 1'b0;
    chk("flush_count", 32'(rs_count), 0);
    chk("flush_valid", 32'(exec_valid), 0);
    chk("flush_full", 32'(rs_full), 0);

    // Asynchronous reset mid-run
    disp(2, 3, 2, 1'b1, 0);
    tick();
    disp(3, 3, 3, 1'b1, 0);
    tick();
    write_en = 1'b0;
    chk("pre_rst_count", 32'(rs_count), 2);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_count", 32'(rs_count), 0);
    chk("async_rst_valid", 32'(exec_valid), 0);
    chk("async_rst_rob", 32'(exec_rob_idx), 0);
    rst_n = 1'b1;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
